// File: rtl/bru_pkg.sv
// Shared constants and types for the branch resolve unit: funct3 encodings,
// the 2-bit counter type and its saturating update helper.
package bru_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_INIT = 2'b01;

    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t nxt;
        nxt = cnt;
        if (taken && cnt != 2'b11)
            nxt = cnt + 2'b01;
        else if (!taken && cnt != 2'b00)
            nxt = cnt - 2'b01;
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational RV64I conditional-branch evaluator. funct3 010/011 have no
// branch meaning and are flagged illegal with cond held low.
module branch_cmp
    import bru_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            cond_o,
    output logic            illegal_o
);

    logic eq, lt, ltu;

    assign eq  = (a_i == b_i);
    assign lt  = ($signed(a_i) < $signed(b_i));
    assign ltu = (a_i < b_i);

    always_comb begin
        cond_o    = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond_o = eq;
            F3_BNE:  cond_o = ~eq;
            F3_BLT:  cond_o = lt;
            F3_BGE:  cond_o = ~lt;
            F3_BLTU: cond_o = ltu;
            F3_BGEU: cond_o = ~ltu;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution plus a table of 2-bit saturating predictors.
// Optional statistics counters are enabled with the BRU_STATS_EN macro.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic            res_branch,
    input  logic [2:0]      res_funct3,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_pred,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            sel,
    output logic            taken_q,
    output logic            mispredict_q,
    output logic            illegal_q,
`ifdef BRU_STATS_EN
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count,
`endif
    output logic            done_q
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    bht_cnt_t         bht_q [BHT_DEPTH];
    logic [IDX_W-1:0] lk_idx, res_idx;
    logic             cond, illegal;
    logic             br_vld, upd;
    logic             taken_d, mispredict_d, illegal_d, done_d;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3_i  (res_funct3),
        .a_i       (rs1_data),
        .b_i       (rs2_data),
        .cond_o    (cond),
        .illegal_o (illegal)
    );

    // Word-aligned index; low PC bits and upper tag bits play no part.
    assign lk_idx  = lookup_pc[IDX_W+1:2];
    assign res_idx = res_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0],
                              res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

    assign pred_taken = bht_q[lk_idx][1];

    assign br_vld       = res_valid & res_branch;
    assign sel          = br_vld & ~illegal & cond;
    assign upd          = br_vld & ~illegal;
    assign taken_d      = sel;
    assign mispredict_d = upd & (res_pred != sel);
    assign illegal_d    = br_vld & illegal;
    assign done_d       = br_vld;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                bht_q[i] <= BHT_INIT;
        end else if (upd) begin
            bht_q[res_idx] <= bht_next(bht_q[res_idx], sel);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
            illegal_q    <= illegal_d;
            done_q       <= done_d;
        end
    end

`ifdef BRU_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (done_d && br_cnt_q != 32'hFFFF_FFFF)
            br_cnt_d = br_cnt_q + 32'd1;
        if (mispredict_d && mis_cnt_q != 32'hFFFF_FFFF)
            mis_cnt_d = mis_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: compares, training/saturation,
// illegal funct3, same-cycle lookup/update and asynchronous reset.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] lookup_pc;
    logic        pred_taken;
    logic        res_valid, res_branch, res_pred;
    logic [2:0]  res_funct3;
    logic [63:0] res_pc, rs1_data, rs2_data;
    logic        sel, taken_q, mispredict_q, illegal_q, done_q;
`ifdef BRU_STATS_EN
    logic [31:0] br_count, mispred_count;
`endif

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.XLEN(64), .BHT_DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .lookup_pc    (lookup_pc),
        .pred_taken   (pred_taken),
        .res_valid    (res_valid),
        .res_branch   (res_branch),
        .res_funct3   (res_funct3),
        .res_pc       (res_pc),
        .res_pred     (res_pred),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .sel          (sel),
        .taken_q      (taken_q),
        .mispredict_q (mispredict_q),
        .illegal_q    (illegal_q),
`ifdef BRU_STATS_EN
        .br_count     (br_count),
        .mispred_count(mispred_count),
`endif
        .done_q       (done_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic res(input logic v, input logic br, input logic [2:0] f3,
                       input logic [63:0] pc, input logic [63:0] a,
                       input logic [63:0] b, input logic pred);
        res_valid  = v;
        res_branch = br;
        res_funct3 = f3;
        res_pc     = pc;
        rs1_data   = a;
        rs2_data   = b;
        res_pred   = pred;
    endtask

    task automatic chk_q(input string tag, input logic t, input logic m,
                         input logic il, input logic d);
        chk({tag, ".taken_q"},      taken_q,      t);
        chk({tag, ".mispredict_q"}, mispredict_q, m);
        chk({tag, ".illegal_q"},    illegal_q,    il);
        chk({tag, ".done_q"},       done_q,       d);
    endtask

    // Drive at negedge, check sel/pred_taken, clock, check registered outputs.
    task automatic step(input string tag, input logic v, input logic br,
                        input logic [2:0] f3, input logic [63:0] pc,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic pred, input logic exp_sel,
                        input logic t, input logic m, input logic il, input logic d);
        @(negedge clk);
        res(v, br, f3, pc, a, b, pred);
        #1;
        chk({tag, ".sel"}, sel, exp_sel);
        @(posedge clk);
        #1;
        chk_q(tag, t, m, il, d);
    endtask

    initial begin
        reset     = 1'b1;
        lookup_pc = 64'h0;
        res(1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 64'h0, 1'b0);
        #2;
        chk("rst.pred_taken", pred_taken, 1'b0);
        chk_q("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // compares on idx 1 (pc 0x104)
        step("blt_neg1_1", 1, 1, 3'b100, 64'h104, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 1, 1, 1, 0, 1);
        step("bltu_max_1", 1, 1, 3'b110, 64'h104, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 0, 0, 0, 1);
        step("bgeu_max_1", 1, 1, 3'b111, 64'h104, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1, 1, 1, 0, 0, 1);
        step("bge_neg1_1", 1, 1, 3'b101, 64'h104, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1, 0, 0, 1, 0, 1);
        step("bne_ne",     1, 1, 3'b001, 64'h104, 64'h5, 64'h6, 1, 1, 1, 0, 0, 1);
        step("beq_ne",     1, 1, 3'b000, 64'h104, 64'h5, 64'h6, 0, 0, 0, 0, 0, 1);

        // training on idx 0 via pc 0x40, back-to-back
        lookup_pc = 64'h40;
        step("train1", 1, 1, 3'b000, 64'h40, 64'h7, 64'h7, 0, 1, 1, 1, 0, 1);
        chk("train1.pred", pred_taken, 1'b1);
        step("train2", 1, 1, 3'b000, 64'h40, 64'h7, 64'h7, 0, 1, 1, 1, 0, 1);
        chk("train2.pred", pred_taken, 1'b1);
        step("train3", 1, 1, 3'b000, 64'h40, 64'h7, 64'h7, 1, 1, 1, 0, 0, 1);
        // counter should be saturated at 3: one not-taken keeps it strong enough
        step("nt1", 1, 1, 3'b001, 64'h40, 64'h7, 64'h7, 1, 0, 0, 1, 0, 1);
        chk("nt1.pred", pred_taken, 1'b1);
        step("ill010", 1, 1, 3'b010, 64'h40, 64'h7, 64'h7, 1, 0, 0, 0, 1, 1);
        chk("ill010.pred", pred_taken, 1'b1);
        step("ill011", 1, 1, 3'b011, 64'h40, 64'h3, 64'h5, 0, 0, 0, 0, 1, 1);
        step("nt2", 1, 1, 3'b001, 64'h40, 64'h7, 64'h7, 0, 0, 0, 0, 0, 1);
        chk("nt2.pred", pred_taken, 1'b0);

        step("nonbranch", 1, 0, 3'b000, 64'h40, 64'h7, 64'h7, 0, 0, 0, 0, 0, 0);
        step("invalid",   0, 1, 3'b000, 64'h40, 64'h7, 64'h7, 0, 0, 0, 0, 0, 0);
        chk("invalid.pred", pred_taken, 1'b0);

        // same-cycle lookup and update on idx 0 (counter 1)
        @(negedge clk);
        lookup_pc = 64'h80;
        res(1, 1, 3'b000, 64'h80, 64'h9, 64'h9, 0);
        #1;
        chk("bypass.pred_before", pred_taken, 1'b0);
        @(posedge clk);
        #1;
        chk("bypass.pred_after", pred_taken, 1'b1);

        // train idx 5 to 3, then reset mid-stream
        lookup_pc = 64'h14;
        step("idx5a", 1, 1, 3'b000, 64'h14, 64'h1, 64'h1, 0, 1, 1, 1, 0, 1);
        step("idx5b", 1, 1, 3'b000, 64'h14, 64'h1, 64'h1, 0, 1, 1, 1, 0, 1);
        chk("idx5.pred", pred_taken, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst.pred", pred_taken, 1'b0);
        chk_q("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BRU_STATS_EN
        chk("midrst.br_count", br_count, 32'd0);
        chk("midrst.mispred_count", mispred_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        chk_q("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        res(0, 0, 3'b000, 64'h0, 64'h0, 64'h0, 0);
        #1;
        chk("postrst.pred", pred_taken, 1'b0);
        @(posedge clk);
        #1;
        chk_q("postrst", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution and prediction unit for the single-cycle RISC-V core. It evaluates all six RV64I conditional branches (beq, bne, blt, bge, bltu, bgeu) on full-width operands and produces the PC-select. It also holds a table of 2-bit saturating counters: the counters supply a taken/not-taken prediction at fetch and are trained at resolve. Registered resolve outputs (taken, mispredict, illegal) feed the PC mux and the flush logic.

## Interface
- XLEN, 64, operand and PC width
- BHT_DEPTH, 16, number of counters; power of two, ≥2
- IDX_W, $clog2(BHT_DEPTH), table index width (derived, not overridden)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- lookup_pc  in  XLEN  fetch PC for prediction
- pred_taken  out  1  prediction for lookup_pc (combinational read of table)
- res_valid  in  1  resolve request this cycle
- res_branch  in  1  instruction is a conditional branch
- res_funct3  in  3  branch condition
- res_pc  in  XLEN  PC of resolving branch
- res_pred  in  1  prediction made for this branch at fetch
- rs1_data, rs2_data  in  XLEN  operands
- sel  out  1  combinational branch taken (res_valid & res_branch & condition true)
- taken_q  out  1  registered sel
- mispredict_q  out  1  registered (res_pred != sel) for a valid branch
- illegal_q  out  1  registered: valid branch with funct3 010 or 011
- done_q  out  1  registered res_valid & res_branch

## Operation
- Conditions: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. Signed compares use the two's-complement interpretation of XLEN bits.
- 010/011: sel=0, illegal_q=1 next cycle, table not updated, mispredict_q forced 0.
- res_valid=0 or res_branch=0: sel=0. No table update. All *_q outputs 0 next cycle.
- Index = pc[IDX_W+1:2] for both lookup and resolve. Bits [1:0] are ignored.
- pred_taken = counter[idx][1].
- Update on a valid, legal branch at the clock edge: if taken, counter+1, saturating at 3; else counter−1, saturating at 0.
- Same-index lookup and update in one cycle: pred_taken returns the pre-update value (no bypass).

## Timing
- sel: zero latency, combinational.
- *_q outputs: one cycle after the resolve request; each is valid for exactly one cycle.
- Back-to-back resolves are allowed every cycle, and successive updates to the same index accumulate correctly.
- On reset assertion, taking effect immediately: all counters = 2'b01 (weakly not-taken); taken_q, mispredict_q, illegal_q, done_q = 0. Stats counters (if present) = 0.
- A resolve request coincident with reset is dropped, with no update.

## Configuration
- BRU_STATS_EN defined: adds outputs br_count and mispred_count, both 32 bits. br_count increments on each done_q-qualifying branch; mispred_count increments on each mispredict. Both saturate at 2^32−1 and are cleared by reset.
- BRU_STATS_EN undefined: these ports and registers do not exist. All other behaviour is identical.

## Structure
- Package bru_pkg holds:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - counter typedef bht_cnt_t (2-bit)
  - reset constant BHT_INIT = 2'b01
- Sub-module branch_cmp is purely combinational. It takes funct3, a and b (XLEN) and outputs cond and illegal.
- The top level holds the counter array, update logic, output registers and the optional stats.

## Test plan
- Reset, then lookup_pc=0x0 → pred_taken=0. All *_q = 0.
- Operand checks (funct3 → sel):
  - a=0xFFFF_FFFF_FFFF_FFFF, b=1, funct3=100 → sel=1 (signed −1<1)
  - same operands, funct3=110 → sel=0
  - funct3=111 → sel=1
- Training: resolve pc=0x40 taken twice, res_pred=0 → mispredict_q=1 both times. lookup_pc=0x40 then gives pred_taken=1 and the counter reads 3. A third taken resolve leaves the counter at 3.
- funct3=010 with a==b → sel=0, illegal_q=1, mispredict_q=0, counter unchanged.
- Same-cycle lookup and resolve at pc=0x80, counter=1, taken → pred_taken=0 that cycle and pred_taken=1 the next cycle.
- Assert reset mid-stream after training index 5 to 3 → counter returns to 1 immediately, *_q = 0. With BRU_STATS_EN defined, br_count and mispred_count = 0.
